// File: rtl/shift_add_step.sv
// shift_add_step: sequential shift-add multiply by a fixed coefficient.
//
// Responder side of the step start/done handshake. On a start request the
// operand is captured, then one coefficient bit is processed per clock edge
// (WIDTH edges). The product is saturated (SAT=1) or truncated (SAT=0) to
// WIDTH bits and presented with a one-cycle done pulse. The clock may be
// gated by the sequencer; all state simply holds while no edges arrive.
//
// Ports:
//   clk      in   step clock (possibly gated)
//   rst_n    in   asynchronous active-low reset
//   start    in   level request, held high until done is seen
//   in_data  in   operand, sampled only on the capture edge
//   out_data out  registered result, held until the next completed operation
//   done     out  registered, high for exactly one cycle per completion
//   busy     out  high while calculating and during the done cycle
module shift_add_step #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] COEF  = 8'd5,
    parameter bit               SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic             done,
    output logic             busy
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CALC     = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;

    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] sum;
    logic [WIDTH-1:0]   result;

    // Partial product for the coefficient bit selected by the counter, and the
    // running sum including it. On the last bit, sum is the full product.
    always_comb begin
        partial = '0;
        if (COEF[cnt_q]) begin
            partial = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
        end
        sum = acc_q + partial;
        if (SAT && (|sum[2*WIDTH-1:WIDTH])) begin
            result = '1;
        end else begin
            result = sum[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = in_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Dropping start aborts, even on the final-bit edge.
                if (!start) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = sum;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d      = '0;
                        out_data_d = result;
                        state_d    = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = start ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: begin
                // Blocks a still-high start from retriggering.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q == ST_CALC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_add_step.sv
// Testbench for shift_add_step: two instances (saturating and truncating)
// share clock and stimulus; results are compared against a plain-arithmetic
// product model with a fixed WIDTH+1 edge latency.
module tb_shift_add_step;

    localparam int unsigned W    = 8;
    localparam int          COEF = 5;
    localparam int          MAXV = (1 << W) - 1;
    localparam int          LAT  = W + 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in_data;
    logic [W-1:0] out_s, out_t;
    logic         done_s, done_t, busy_s, busy_t;
    bit           clk_run;

    int n_pass;
    int n_total;
    int last_s;
    int last_t;

    typedef struct {
        logic [W-1:0] a;
        int           exp_s;
        int           exp_t;
    } vec_t;

    vec_t vecs[8];

    shift_add_step #(.WIDTH(W), .COEF(8'd5), .SAT(1'b1)) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .out_data (out_s),
        .done     (done_s),
        .busy     (busy_s)
    );

    shift_add_step #(.WIDTH(W), .COEF(8'd5), .SAT(1'b0)) u_dut_trn (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .out_data (out_t),
        .done     (done_t),
        .busy     (busy_t)
    );

    // Gateable clock: while clk_run is low no edges are produced.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int model(input int a, input bit sat);
        int p;
        p = a * COEF;
        if (sat) return (p > MAXV) ? MAXV : p;
        return p % (MAXV + 1);
    endfunction

    // One full operation. gate_at: stop the clock for 6 periods after that
    // edge (0 = never). hold_after: edges to keep start high after done.
    task automatic run_op(input logic [W-1:0] a, input int gate_at, input int hold_after,
                          input int exp_s, input int exp_t, input string tag);
        int  busy_cnt;
        int  done_cnt_s;
        int  done_cnt_t;
        int  done_edge;
        int  held;
        bit  dropped;
        busy_cnt   = 0;
        done_cnt_s = 0;
        done_cnt_t = 0;
        done_edge  = 0;
        held       = 0;
        dropped    = 1'b0;
        in_data    = a;
        start      = 1'b1;
        for (int e = 1; e <= LAT + 8 + hold_after; e++) begin
            tick();
            if (e == 1) in_data = W'($urandom);
            if (busy_s) busy_cnt++;
            if (done_t) done_cnt_t++;
            if (done_s) begin
                done_cnt_s++;
                if (done_edge == 0) done_edge = e;
            end
            if (e == gate_at) begin
                clk_run = 1'b0;
                #60;
                check({tag, " gated busy"}, int'(busy_s), 1);
                check({tag, " gated done"}, int'(done_s), 0);
                check({tag, " gated out"}, int'(out_s), last_s);
                clk_run = 1'b1;
            end
            if (dropped) break;
            if (done_edge != 0) begin
                if (held >= hold_after) begin
                    start   = 1'b0;
                    dropped = 1'b1;
                end else begin
                    held++;
                end
            end
        end
        if (!dropped) begin
            start = 1'b0;
            tick();
        end
        check({tag, " done edge"}, done_edge, LAT);
        check({tag, " done pulses sat"}, done_cnt_s, 1);
        check({tag, " done pulses trn"}, done_cnt_t, 1);
        check({tag, " busy cycles"}, busy_cnt, LAT);
        check({tag, " out sat"}, int'(out_s), exp_s);
        check({tag, " out trn"}, int'(out_t), exp_t);
        last_s = exp_s;
        last_t = exp_t;
    endtask

    // Start an operation, then drop start just before edge abort_edge.
    task automatic abort_op(input logic [W-1:0] a, input int abort_edge, input string tag);
        int done_cnt;
        in_data  = a;
        start    = 1'b1;
        done_cnt = 0;
        for (int e = 1; e < abort_edge; e++) begin
            tick();
            if (done_s || done_t) done_cnt++;
        end
        start = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            if (done_s || done_t) done_cnt++;
        end
        check({tag, " no done"}, done_cnt, 0);
        check({tag, " busy low"}, int'(busy_s), 0);
        check({tag, " out sat held"}, int'(out_s), last_s);
        check({tag, " out trn held"}, int'(out_t), last_t);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        last_s  = 0;
        last_t  = 0;
        clk_run = 1'b1;
        rst_n   = 1'b0;
        start   = 1'b0;
        in_data = '0;

        vecs[0] = '{a: 8'd20,  exp_s: 100, exp_t: 100};
        vecs[1] = '{a: 8'd60,  exp_s: 255, exp_t: 44};
        vecs[2] = '{a: 8'd0,   exp_s: 0,   exp_t: 0};
        vecs[3] = '{a: 8'd1,   exp_s: 5,   exp_t: 5};
        vecs[4] = '{a: 8'd51,  exp_s: 255, exp_t: 255};
        vecs[5] = '{a: 8'd52,  exp_s: 255, exp_t: 4};
        vecs[6] = '{a: 8'd255, exp_s: 255, exp_t: 251};
        vecs[7] = '{a: 8'd3,   exp_s: 15,  exp_t: 15};

        repeat (2) tick();
        check("reset out", int'(out_s), 0);
        check("reset done", int'(done_s), 0);
        check("reset busy", int'(busy_s), 0);
        rst_n = 1'b1;
        tick();
        check("idle no busy", int'(busy_s), 0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, 0, 0, vecs[i].exp_s, vecs[i].exp_t, $sformatf("vec%0d", i));
        end

        // start held high 5 edges after done, then one low edge before reuse.
        run_op(8'd20, 0, 5, 100, 100, "hold");
        run_op(8'd3, 0, 0, 15, 15, "after_hold");

        abort_op(8'd7, 5, "abort5");
        abort_op(8'd60, LAT, "abort_last");
        run_op(8'd7, 0, 0, 35, 35, "after_abort");

        // Reset mid-calculation with the clock stopped.
        in_data = 8'd60;
        start   = 1'b1;
        repeat (3) tick();
        clk_run = 1'b0;
        start   = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async rst out", int'(out_s), 0);
        check("async rst done", int'(done_s), 0);
        check("async rst busy", int'(busy_s), 0);
        #5;
        rst_n   = 1'b1;
        clk_run = 1'b1;
        tick();
        check("post rst idle", int'(busy_s), 0);
        last_s = 0;
        last_t = 0;
        run_op(8'd1, 0, 0, 5, 5, "after_rst");

        run_op(8'd51, 4, 0, 255, 255, "gated");

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a;
            int           g;
            a = W'($urandom_range(0, MAXV));
            g = int'($urandom_range(0, W));
            run_op(a, g, int'($urandom_range(0, 2)), model(int'(a), 1'b1), model(int'(a), 1'b0),
                   $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
